// File: rtl/pipe_control.sv
// Sequencer and hazard controller for the Y86-64 PIPE stage registers.
// Generates the en/res pair of every stage register (F, D, E, M, W), runs an
// IDLE -> FLUSH -> RUN -> HALTED sequence, supports a debug freeze in RUN and
// keeps saturating counts of stalled and bubbled RUN cycles.
//
// Stage register contract: en=1 loads the stage, en=0/res=1 loads the reset
// value (bubble), en=0/res=0 holds. The outputs below never raise res while en=1.
module pipe_control #(
  parameter int FLUSH_CYCLES = 5,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  input  logic             freeze,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_en,
  output logic             F_res,
  output logic             D_en,
  output logic             D_res,
  output logic             E_en,
  output logic             E_res,
  output logic             M_en,
  output logic             M_res,
  output logic             W_en,
  output logic             W_res,
  output logic [1:0]       state,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] flush_cnt;
  logic [3:0] nxt_flush_cnt;

  logic load_use, ret, mispred, exc_m, exc_w;
  logic f_stall, d_stall, d_bub, e_bub, m_bub, w_stall;
  logic run_active;

  assign state      = cur_state;
  assign halted     = (cur_state == S_HALTED);
  assign run_active = (cur_state == S_RUN) && !freeze;

  // Hazard detection, purely combinational from the current stage contents.
  always_comb begin
    load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE)
               && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret      = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    mispred  = (E_icode == IJXX) && !e_Cnd;
    exc_m    = (m_stat != SAOK);
    exc_w    = (W_stat != SAOK);
    f_stall  = load_use || ret;
    d_stall  = load_use;
    d_bub    = mispred || (!load_use && ret);
    e_bub    = mispred || load_use;
    m_bub    = exc_m || exc_w;
    w_stall  = exc_w;
  end

  // Stage controls: hold outside RUN/FLUSH, bubble everything in FLUSH,
  // hazard-driven in unfrozen RUN. A bubble overrides a stall on the same stage.
  always_comb begin
    F_en = 1'b0; F_res = 1'b0;
    D_en = 1'b0; D_res = 1'b0;
    E_en = 1'b0; E_res = 1'b0;
    M_en = 1'b0; M_res = 1'b0;
    W_en = 1'b0; W_res = 1'b0;
    if (cur_state == S_FLUSH) begin
      F_res = 1'b1; D_res = 1'b1; E_res = 1'b1; M_res = 1'b1; W_res = 1'b1;
    end else if (run_active) begin
      F_en  = !f_stall;
      D_en  = !d_stall && !d_bub;
      D_res = d_bub;
      E_en  = !e_bub;
      E_res = e_bub;
      M_en  = !m_bub;
      M_res = m_bub;
      W_en  = !w_stall;
    end
  end

  // Only D can see stall and bubble together; bubble wins, but flag it.
  a_d_stall_and_bubble: assert property (
    @(posedge clk) disable iff (!res_n) !(run_active && d_stall && d_bub)
  );

  // Next-state and flush counter sequencing.
  always_comb begin
    nxt_state     = cur_state;
    nxt_flush_cnt = flush_cnt;
    case (cur_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          nxt_state     = S_FLUSH;
          nxt_flush_cnt = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == 4'd0) nxt_state = S_RUN;
        else                   nxt_flush_cnt = flush_cnt - 4'd1;
      end
      S_RUN: begin
        if (run_active && exc_w) nxt_state = S_HALTED;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // State register and flush counter.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cur_state <= S_IDLE;
      flush_cnt <= 4'd0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= nxt_flush_cnt;
    end
  end

  // Final status capture on the RUN -> HALTED edge; held until reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      final_stat <= 3'd0;
    end else if (run_active && exc_w) begin
      final_stat <= W_stat;
    end
  end

  // Saturating stall and bubble counters, active only in unfrozen RUN.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (run_active) begin
      if (!F_en && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if ((D_res || E_res || M_res) && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control with FLUSH_CYCLES=3 and 4-bit counters so
// saturation is reachable. Inputs change just after a falling edge; outputs
// are sampled 1ns later (combinational) or at the following falling edge.
module tb_pipe_control;

  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 4;

  // Control vector order: {F_en,F_res,D_en,D_res,E_en,E_res,M_en,M_res,W_en,W_res}
  localparam logic [9:0] C_HOLD  = 10'b00_00_00_00_00;
  localparam logic [9:0] C_FLUSH = 10'b01_01_01_01_01;
  localparam logic [9:0] C_RUN   = 10'b10_10_10_10_10;

  logic             clk, res_n, start, freeze, e_Cnd;
  logic [3:0]       D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic [2:0]       m_stat, W_stat;
  logic             F_en, F_res, D_en, D_res, E_en, E_res, M_en, M_res, W_en, W_res;
  logic [1:0]       state;
  logic             halted;
  logic [2:0]       final_stat;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  logic [9:0]       ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl = {F_en, F_res, D_en, D_res, E_en, E_res, M_en, M_res, W_en, W_res};

  pipe_control #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .res_n(res_n), .start(start), .freeze(freeze),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_en(F_en), .F_res(F_res), .D_en(D_en), .D_res(D_res), .E_en(E_en), .E_res(E_res),
    .M_en(M_en), .M_res(M_res), .W_en(W_en), .W_res(W_res),
    .state(state), .halted(halted), .final_stat(final_stat),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic next_neg();
    @(negedge clk);
  endtask

  task automatic clear_hazards();
    D_icode = 4'h0; E_icode = 4'h0; M_icode = 4'h0;
    E_dstM  = 4'hF; d_srcA  = 4'hF; d_srcB  = 4'hF;
    e_Cnd   = 1'b1; m_stat  = 3'd1; W_stat  = 3'd1;
  endtask

  initial begin
    res_n = 1'b0; start = 1'b0; freeze = 1'b0;
    clear_hazards();

    // Reset state
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'(C_HOLD));
    check("rst_cnts", {stall_cnt, bubble_cnt}, 32'h00);
    check("rst_final", 32'(final_stat), 32'd0);
    #10 res_n = 1'b1;

    // 1. IDLE, start pulse, exactly FLUSH_CYCLES bubble cycles, then RUN
    next_neg();
    check("idle_state", 32'(state), 32'd0);
    check("idle_ctrl", 32'(ctrl), 32'(C_HOLD));
    freeze = 1'b1;   // ignored outside RUN
    start = 1'b1;
    next_neg();
    start = 1'b0;
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      check("flush_state", 32'(state), 32'd1);
      check("flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
      next_neg();
    end
    freeze = 1'b0;
    #1;
    check("run_state", 32'(state), 32'd2);
    check("run_ctrl", 32'(ctrl), 32'(C_RUN));

    // 2. Load-use hazard, then no hazard with RNONE
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1 check("load_use_ctrl", 32'(ctrl), 32'(10'b00_00_01_10_10));
    next_neg();
    check("load_use_cnts", {stall_cnt, bubble_cnt}, 32'h11);
    E_dstM = 4'hF; d_srcA = 4'hF;
    start = 1'b1;    // ignored in RUN
    #1 check("rnone_ctrl", 32'(ctrl), 32'(C_RUN));
    next_neg();
    start = 1'b0;
    check("start_in_run", 32'(state), 32'd2);
    check("rnone_cnts", {stall_cnt, bubble_cnt}, 32'h11);
    // popq load-use via srcB
    E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6;
    #1 check("popq_srcb_ctrl", 32'(ctrl), 32'(10'b00_00_01_10_10));
    next_neg();
    clear_hazards();

    // 3. ret in D
    D_icode = 4'h9;
    #1 check("ret_ctrl", 32'(ctrl), 32'(10'b00_01_10_10_10));
    next_neg();
    check("ret_cnts", {stall_cnt, bubble_cnt}, 32'h33);
    // ret in M only
    D_icode = 4'h0; M_icode = 4'h9;
    #1 check("ret_m_ctrl", 32'(ctrl), 32'(10'b00_01_10_10_10));
    next_neg();
    clear_hazards();

    // 4. Mispredicted jump together with ret, then taken jump
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    #1 check("mispred_ret_ctrl", 32'(ctrl), 32'(10'b00_01_01_10_10));
    next_neg();
    e_Cnd = 1'b1;
    #1 check("taken_ret_ctrl", 32'(ctrl), 32'(10'b00_01_10_10_10));
    next_neg();
    check("jmp_cnts", {stall_cnt, bubble_cnt}, 32'h66);
    clear_hazards();
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1 check("mispred_only_ctrl", 32'(ctrl), 32'(10'b10_01_01_10_10));
    next_neg();
    check("mispred_only_cnts", {stall_cnt, bubble_cnt}, 32'h67);
    clear_hazards();

    // 6a. Freeze in RUN: hold everything, counters frozen
    freeze = 1'b1; D_icode = 4'h9;
    #1 check("freeze_ctrl", 32'(ctrl), 32'(C_HOLD));
    next_neg();
    check("freeze_state", 32'(state), 32'd2);
    check("freeze_cnts", {stall_cnt, bubble_cnt}, 32'h67);
    freeze = 1'b0;

    // Saturation: 12 more stalled+bubbled cycles push both past 15
    for (int i = 0; i < 12; i++) next_neg();
    check("sat_cnts", {stall_cnt, bubble_cnt}, 32'hFF);
    clear_hazards();

    // 5. Memory exception, then writeback halt
    m_stat = 3'd2;
    #1 check("exc_m_ctrl", 32'(ctrl), 32'(10'b10_10_10_01_10));
    next_neg();
    check("exc_m_state", 32'(state), 32'd2);
    W_stat = 3'd4;
    #1 check("exc_w_ctrl", 32'(ctrl), 32'(10'b10_10_10_01_00));
    next_neg();
    clear_hazards();
    check("halt_state", 32'(state), 32'd3);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_final", 32'(final_stat), 32'd4);
    check("halt_ctrl", 32'(ctrl), 32'(C_HOLD));
    check("halt_cnts", {stall_cnt, bubble_cnt}, 32'hFF);
    next_neg();
    check("halt_hold", 32'(state), 32'd3);
    start = 1'b1;
    next_neg();
    start = 1'b0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_ctrl", 32'(ctrl), 32'(C_FLUSH));
    check("restart_final", 32'(final_stat), 32'd4);
    check("restart_halted", 32'(halted), 32'd0);
    for (int i = 0; i < FLUSH_CYCLES; i++) next_neg();
    check("rerun_state", 32'(state), 32'd2);

    // 6b. Asynchronous reset mid-RUN, checked before the next rising edge
    #1 res_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_ctrl", 32'(ctrl), 32'(C_HOLD));
    check("async_cnts", {stall_cnt, bubble_cnt}, 32'h00);
    check("async_final", 32'(final_stat), 32'd0);
    next_neg();
    res_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
